alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Upstream issue/capture stage for the 8-bit combinational ALU.
- Accepts one operation per valid/ready command handshake and holds the operands and opcode stable on the ALU inputs for a programmable settle time.
- Registers the ALU result and flags, then presents them on a valid/ready result interface.
- Keeps a wrapping count of completed operations for debug/status.

Parameters:
- SETTLE_CYCLES, 1, cycles ALU inputs are held before capture; legal 1..15.
- CNT_W, 16, width of completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept command
- cmd_op  input  3  ALU opcode (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 gt, 110 shl A, 111 shl B)
- cmd_a  input  8  operand A
- cmd_b  input  8  operand B
- alu_a  output  8  to ALU A
- alu_b  output  8  to ALU B
- alu_opcode  output  3  to ALU Opcode
- alu_carry_in  output  1  to ALU carry_in
- alu_out  input  8  from ALU out
- alu_carry_out  input  1  from ALU carry_out
- alu_c_flag  input  1  from ALU C_flag
- alu_z_flag  input  1  from ALU Z_flag
- res_valid  output  1  result present
- res_ready  input  1  consumer accepts result
- res_data  output  8  captured ALU result
- res_carry  output  1  captured carry_out; 0 for non-add/sub ops
- res_c_flag  output  1  captured C_flag (A>B)
- res_z_flag  output  1  captured Z_flag
- op_count  output  CNT_W  completed operations, wraps

Behaviour:
- FSM states: IDLE, EXEC, DONE.
- Reset (async, rst=1):
  - State goes to IDLE.
  - alu_a, alu_b, alu_opcode, alu_carry_in are 0.
  - res_* are 0 and res_valid is 0.
  - op_count is 0.
  - cmd_ready is forced 0 while rst is high.
- Reset mid-operation aborts the operation with no result, no count increment, and no partial output.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready at edge N: latch cmd_a/cmd_b/cmd_op into the ALU drive registers; set alu_carry_in=1 if cmd_op==001, else 0; load settle counter with SETTLE_CYCLES-1; go to EXEC.
- EXEC:
  - cmd_ready=0.
  - ALU drive registers are stable.
  - The counter decrements each cycle. On the edge where the counter is 0:
    - Capture alu_out→res_data, alu_c_flag→res_c_flag, alu_z_flag→res_z_flag.
    - Capture alu_carry_out→res_carry if the latched op is 000/001, else 0.
    - Set res_valid=1 and go to DONE.
  - With SETTLE_CYCLES=1, res_valid is first high after edge N+1.
- DONE:
  - cmd_ready=0.
  - res_* are held stable while res_valid=1 && res_ready=0.
  - ALU drive registers keep their values.
  - On res_valid&res_ready: res_valid→0, op_count increments, go to IDLE.
  - res_data/flags keep their last values after the handshake; only res_valid drops.
- Throughput: one op per SETTLE_CYCLES+2 cycles when res_ready is held 1.
- cmd_valid during EXEC/DONE is ignored (not accepted). The source must hold the command until cmd_ready.
- op_count wraps from 2^CNT_W-1 to 0 with no flag.
- res_ready asserted while res_valid=0 has no effect.
- No combinational path from cmd_* or alu_* inputs to any output. cmd_ready is a function of state and rst only.

Test Plan:
- rst pulse asserted asynchronously in DONE holding a result -> res_valid=0, op_count=0, cmd_ready=0 during reset, 1 the cycle after release; no result emitted.
- ADD A=0xFF, B=0x01, res_ready=1, SETTLE_CYCLES=1 -> alu_carry_in=0; res_valid rises 1 edge after acceptance; res_data=0x00, res_carry=1, res_z_flag=1, res_c_flag=1; op_count=1.
- SUB A=0x05, B=0x05 -> alu_carry_in=1, res_data=0x00, res_z_flag=1, res_c_flag=0; then XOR A=0xA5, B=0x0F -> res_data=0xAA, res_carry=0, res_z_flag=0.
- SHL A=0x81 with res_ready held 0 for 5 cycles -> res_data=0x02 stable, res_valid held, cmd_ready=0, second cmd_valid not accepted; accepted only after result handshake + return to IDLE.
- SETTLE_CYCLES=4, back-to-back AND commands with res_ready=1 -> each res_valid 4 edges after acceptance, accept spacing 6 cycles, op_count increments once per result.
- CNT_W=4, 17 ops -> op_count wraps 15→0 and reads 1 at end.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Bundle of command, ALU drive/return and result signals around the
// ALU operation sequencer. The slave modport is the sequencer's view;
// the master modport is the surrounding environment's view.
interface alu_op_sequencer_if #(
  parameter int CNT_W = 16
);
  // Command channel
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  // ALU drive
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [2:0]       alu_opcode;
  logic             alu_carry_in;
  // ALU return
  logic [7:0]       alu_out;
  logic             alu_carry_out;
  logic             alu_c_flag;
  logic             alu_z_flag;
  // Result channel
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;
  logic             res_carry;
  logic             res_c_flag;
  logic             res_z_flag;
  // Status
  logic [CNT_W-1:0] op_count;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    input  alu_out, alu_carry_out, alu_c_flag, alu_z_flag,
    input  res_ready,
    output cmd_ready,
    output alu_a, alu_b, alu_opcode, alu_carry_in,
    output res_valid, res_data, res_carry, res_c_flag, res_z_flag,
    output op_count
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    output alu_out, alu_carry_out, alu_c_flag, alu_z_flag,
    output res_ready,
    input  cmd_ready,
    input  alu_a, alu_b, alu_opcode, alu_carry_in,
    input  res_valid, res_data, res_carry, res_c_flag, res_z_flag,
    input  op_count
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue/capture stage for an 8-bit combinational ALU: accepts one command,
// holds the ALU inputs for SETTLE_CYCLES, registers the result and flags,
// and offers them on a valid/ready result channel.
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input logic               clk,
  input logic               rst,
  alu_op_sequencer_if.slave bus
);
  // Counter starts at SETTLE_CYCLES-1 so capture happens SETTLE_CYCLES edges after accept
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [3:0]       settle_reg;
  logic [7:0]       a_reg;
  logic [7:0]       b_reg;
  logic [2:0]       op_reg;
  logic             cin_reg;
  logic [7:0]       data_reg;
  logic             carry_reg;
  logic             c_reg;
  logic             z_reg;
  logic             valid_reg;
  logic [CNT_W-1:0] count_reg;

  logic cmd_ready;
  logic accept;
  logic capture;
  logic res_done;

  // Ready depends only on state and reset, never on the command inputs
  assign cmd_ready = (state_reg == IDLE) && !rst;
  assign accept    = bus.cmd_valid && cmd_ready;
  assign capture   = (state_reg == EXEC) && (settle_reg == 4'd0);
  assign res_done  = (state_reg == DONE) && valid_reg && bus.res_ready;

  // Next-state decode
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)   state_next = EXEC;
      EXEC:    if (capture)  state_next = DONE;
      DONE:    if (res_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // ALU drive registers: loaded on accept, held through EXEC and DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= 8'h00;
      b_reg   <= 8'h00;
      op_reg  <= 3'b000;
      cin_reg <= 1'b0;
    end else if (accept) begin
      a_reg   <= bus.cmd_a;
      b_reg   <= bus.cmd_b;
      op_reg  <= bus.cmd_op;
      cin_reg <= (bus.cmd_op == 3'b001);
    end
  end

  // Settle counter: loaded on accept, counts down while the ALU settles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         settle_reg <= 4'd0;
    else if (accept)                                 settle_reg <= SETTLE_LOAD;
    else if (state_reg == EXEC && settle_reg != 4'd0) settle_reg <= settle_reg - 4'd1;
  end

  // Result capture; data and flags persist after the handshake, only valid drops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg  <= 8'h00;
      carry_reg <= 1'b0;
      c_reg     <= 1'b0;
      z_reg     <= 1'b0;
      valid_reg <= 1'b0;
    end else if (capture) begin
      data_reg  <= bus.alu_out;
      carry_reg <= (op_reg == 3'b000 || op_reg == 3'b001) ? bus.alu_carry_out : 1'b0;
      c_reg     <= bus.alu_c_flag;
      z_reg     <= bus.alu_z_flag;
      valid_reg <= 1'b1;
    end else if (res_done) begin
      valid_reg <= 1'b0;
    end
  end

  // Completed-operation counter, wraps silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           count_reg <= '0;
    else if (res_done) count_reg <= count_reg + 1'b1;
  end

  assign bus.cmd_ready    = cmd_ready;
  assign bus.alu_a        = a_reg;
  assign bus.alu_b        = b_reg;
  assign bus.alu_opcode   = op_reg;
  assign bus.alu_carry_in = cin_reg;
  assign bus.res_valid    = valid_reg;
  assign bus.res_data     = data_reg;
  assign bus.res_carry    = carry_reg;
  assign bus.res_c_flag   = c_reg;
  assign bus.res_z_flag   = z_reg;
  assign bus.op_count     = count_reg;
endmodule
